// File: rtl/jetpack_pkg.sv
// jetpack_pkg: shared game-state type, screen and Barry geometry, and the
// laser LFSR helpers used by the Jetpack game blocks.
package jetpack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } game_state_e;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;

    localparam int BARRY_X      = 100;
    localparam int BARRY_W      = 32;
    localparam int BARRY_H      = 48;
    localparam int BARRY_Y_MIN  = 4;
    localparam int BARRY_Y_MAX  = 420;

    localparam int LASER_W      = 16;
    localparam int LASER_H      = 64;
    localparam int SPEED        = 4;
    localparam int FLASH_FRAMES = 30;
    localparam int SCORE_W      = 16;

    // Laser spawn row is the LFSR value lifted clear of the top HUD strip.
    localparam int LASER_Y_BASE = 64;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

    function automatic logic [8:0] spawn_y(input logic [7:0] rnd);
        return {1'b0, rnd} + 9'(LASER_Y_BASE);
    endfunction

endpackage

// File: rtl/laser_collide_lfsr8.sv
// lfsr8: 8-bit right-shifting Galois LFSR (taps 8'hB8, seed 8'hA5) that
// steps once per cycle with en high; a nonzero seed keeps it out of zero.
module lfsr8
    import jetpack_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // NOTE: the next-state default is assigned first so no path leaves q_d
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = lfsr_next(q_q);
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples the
    // values from before the edge, whatever the order of the processes.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/laser_collide.sv
// laser_collide: one scrolling laser, Barry overlap detection, the
// IDLE/RUN/HIT/OVER game FSM and the frame score. LASER_COLLIDE_LIVES_EN adds lives.
module laser_collide #(
    parameter int SCREEN_W     = jetpack_pkg::SCREEN_W,
    parameter int BARRY_X      = jetpack_pkg::BARRY_X,
    parameter int BARRY_W      = jetpack_pkg::BARRY_W,
    parameter int BARRY_H      = jetpack_pkg::BARRY_H,
    parameter int LASER_W      = jetpack_pkg::LASER_W,
    parameter int LASER_H      = jetpack_pkg::LASER_H,
    parameter int SPEED        = jetpack_pkg::SPEED,
    parameter int FLASH_FRAMES = jetpack_pkg::FLASH_FRAMES,
    parameter int SCORE_W      = jetpack_pkg::SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               start,
    input  logic [8:0]         barry_y,
    output logic [9:0]         laser_x,
    output logic [8:0]         laser_y,
    output logic               laser_active,
    output logic               hit,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
`ifdef LASER_COLLIDE_LIVES_EN
    ,
    output logic [1:0]         lives
`endif
);

    import jetpack_pkg::*;

    localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [9:0]         SPAWN_X    = 10'(SCREEN_W);
    localparam logic [9:0]         STEP_X     = 10'(SPEED);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    localparam logic [10:0] BOX_L   = 11'(BARRY_X);
    localparam logic [10:0] BOX_R   = 11'(BARRY_X + BARRY_W);
    localparam logic [10:0] BOX_H   = 11'(BARRY_H);
    localparam logic [10:0] LASER_WX = 11'(LASER_W);
    localparam logic [10:0] LASER_HY = 11'(LASER_H);

    game_state_e        state_q, state_d;
    logic [9:0]         laser_x_q, laser_x_d;
    logic [8:0]         laser_y_q, laser_y_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [FLASH_W-1:0] flash_q, flash_d;
    logic [8:0]         by_q, by_d;
    logic [7:0]         lfsr_q;
    logic               lfsr_en;
    logic               overlap;

`ifdef LASER_COLLIDE_LIVES_EN
    logic [1:0]         lives_q, lives_d;
`endif

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    // Strict compares: boxes that only share an edge do not collide.
    always_comb begin
        logic [10:0] lx, ly, by;
        lx = {1'b0, laser_x_q};
        ly = {2'b00, laser_y_q};
        by = {2'b00, by_q};
        overlap = (lx < BOX_R) && ((lx + LASER_WX) > BOX_L) &&
                  (ly < (by + BOX_H)) && ((ly + LASER_HY) > by);
    end

    always_comb begin
        state_d   = state_q;
        laser_x_d = laser_x_q;
        laser_y_d = laser_y_q;
        score_d   = score_q;
        flash_d   = flash_q;
        by_d      = frame_start ? barry_y : by_q;
        lfsr_en   = 1'b0;
`ifdef LASER_COLLIDE_LIVES_EN
        lives_d   = lives_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    score_d   = '0;
                    laser_x_d = SPAWN_X;
                    laser_y_d = spawn_y(lfsr_q);
`ifdef LASER_COLLIDE_LIVES_EN
                    lives_d   = 2'd3;
`endif
                end
            end

            RUN: begin
                // A detected hit takes priority over this cycle's motion.
                if (overlap) begin
                    state_d = HIT;
                    flash_d = '0;
`ifdef LASER_COLLIDE_LIVES_EN
                    lives_d = lives_q - 2'd1;
`endif
                end else if (frame_start) begin
                    lfsr_en = 1'b1;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                    if (laser_x_q < STEP_X) begin
                        laser_x_d = SPAWN_X;
                        laser_y_d = spawn_y(lfsr_q);
                    end else begin
                        laser_x_d = laser_x_q - STEP_X;
                    end
                end
            end

            HIT: begin
                if (frame_start) begin
                    if (flash_q == FLASH_LAST) begin
`ifdef LASER_COLLIDE_LIVES_EN
                        if (lives_q != 2'd0) begin
                            state_d   = RUN;
                            laser_x_d = SPAWN_X;
                            laser_y_d = spawn_y(lfsr_q);
                        end else begin
                            state_d   = OVER;
                        end
`else
                        state_d = OVER;
`endif
                    end else begin
                        flash_d = flash_q + 1'b1;
                    end
                end
            end

            OVER: begin
                if (start) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            laser_x_q <= SPAWN_X;
            laser_y_q <= '0;
            score_q   <= '0;
            flash_q   <= '0;
            by_q      <= '0;
        end else begin
            state_q   <= state_d;
            laser_x_q <= laser_x_d;
            laser_y_q <= laser_y_d;
            score_q   <= score_d;
            flash_q   <= flash_d;
            by_q      <= by_d;
        end
    end

`ifdef LASER_COLLIDE_LIVES_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lives_q <= 2'd3;
        end else begin
            lives_q <= lives_d;
        end
    end

    assign lives = lives_q;
`endif

    assign laser_x      = laser_x_q;
    assign laser_y      = laser_y_q;
    assign score        = score_q;
    assign laser_active = (state_q == RUN) || (state_q == HIT);
    assign hit          = (state_q == HIT);
    assign game_over    = (state_q == OVER);

endmodule

// File: doc/laser_collide.md
Name: laser_collide

Overview:
- Downstream consumer of Barry's vertical position (`barry_y`) in the Jetpack game.
- Owns one scrolling laser obstacle and its frame-based motion.
- Detects overlap between the laser and Barry's bounding box, and runs the game state machine (IDLE/RUN/HIT/OVER) and the distance score.
- Outputs feed the VGA renderer and the score display.

Parameters:
SCREEN_W, 640, spawn x of laser (pixels)
BARRY_X, 100, fixed left x of Barry box
BARRY_W, 32, Barry box width
BARRY_H, 48, Barry box height
LASER_W, 16, laser width
LASER_H, 64, laser height
SPEED, 4, laser x decrement per frame
FLASH_FRAMES, 30, frames spent in HIT before OVER
SCORE_W, 16, score width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse per video frame (start of vblank)
start  in  1  one-cycle button pulse, already debounced
barry_y  in  9  Barry top-left y, range 4..420
laser_x  out  10  laser top-left x
laser_y  out  9  laser top-left y
laser_active  out  1  laser visible (RUN or HIT)
hit  out  1  high throughout HIT state
game_over  out  1  high in OVER state
score  out  SCORE_W  frames survived, saturating

Behaviour:
- Reset values:
  - state = IDLE, laser_x = 640, laser_y = 0, laser_active = 0, hit = 0, game_over = 0, score = 0.
  - LFSR = 8'hA5; flash counter = 0; by_q = 0.
  - A reset asserted mid-game takes effect on the next edge and overrides all other events.
- Frame update:
  - All motion, score and LFSR updates occur only on cycles with frame_start = 1.
  - barry_y is sampled into by_q on every frame_start; collision uses by_q, never live barry_y.
- LFSR:
  - 8-bit Galois, taps 8'hB8, advances once per frame_start in RUN. Never zero.
- IDLE:
  - start = 1 -> RUN. Score cleared.
  - Laser spawned: laser_x = SCREEN_W, laser_y = {1'b0, lfsr} + 64 (range 64..319).
  - If start and frame_start coincide, no movement occurs that frame.
- RUN, on frame_start:
  - If laser_x < SPEED, respawn as above; otherwise laser_x -= SPEED.
  - score += 1, saturating at all-ones.
  - start is ignored in RUN.
- Collision:
  - Evaluated combinationally on registered laser_x/laser_y/by_q; result registered into hit_det.
  - Latency: one cycle after the frame_start update edge.
  - Overlap condition, all compares 11-bit unsigned: laser_x < BARRY_X+BARRY_W AND laser_x+LASER_W > BARRY_X AND laser_y < by_q+BARRY_H AND laser_y+LASER_H > by_q.
  - Edge-touching (equality) is not a hit.
- RUN -> HIT:
  - On hit_det = 1: hit = 1, flash counter = 0.
  - laser_x, laser_y and score freeze.
- HIT:
  - Flash counter increments per frame_start.
  - When it reaches FLASH_FRAMES-1 on a frame_start: -> OVER, hit = 0, game_over = 1, laser_active = 0.
- OVER:
  - Score held. start -> IDLE, which clears game_over; score is held until the next IDLE->RUN.
- Simultaneous hit_det and respawn in the same cycle: hit wins; respawn is discarded.

Optional Feature:
Macro `LASER_COLLIDE_LIVES_EN`.
- Defined:
  - Extra port `lives out 2`, reset value 3, reloaded to 3 on IDLE->RUN.
  - Entering HIT decrements lives.
  - At HIT end: if lives != 0, return to RUN with laser respawned, score kept; else -> OVER.
- Undefined:
  - No lives port; every hit ends in OVER as above.

Decomposition:
- Package `jetpack_pkg`:
  - `game_state_e` enum {IDLE, RUN, HIT, OVER}, 2-bit.
  - Screen constants SCREEN_W = 640, SCREEN_H = 480.
  - Barry box constants BARRY_X, BARRY_W, BARRY_H, and the Barry y limits 4/420.
  - The parameters above default from these constants.
- Sub-module `lfsr8`: ports clk, reset, en, q[7:0]; seed 8'hA5; taps 8'hB8.

Test Plan:
- Reset then idle 5 frames -> state IDLE, laser_x = 640, score = 0, laser_active = 0; frame_start without start changes nothing.
- start pulse, then 10 frames with barry_y = 420 (no overlap possible: laser_y + 64 ≤ 383, which is below barry_y = 420) -> laser_x = 600, score = 10, laser_y = 0xA5 + 64 = 229.
- Run 160 frames from spawn with barry_y = 420 -> laser_x reaches 0, respawn on frame 161 to laser_x = 640 with new laser_y; score = 161.
- Force overlap with barry_y = laser_y, laser_x reaching 128 (< BARRY_X+BARRY_W = 132) -> hit = 1 one cycle after that frame's update; score frozen.
  - After 30 frames: game_over = 1, hit = 0.
  - start -> IDLE, game_over = 0.
- Edge case: laser_x = 132 with vertical overlap -> no hit. Reset asserted in HIT -> all outputs return to reset values next edge.
- With `LASER_COLLIDE_LIVES_EN`: three forced hits -> lives 3→2→1→0; RUN resumes after the first two flashes, OVER after the third.
